// File: rtl/sdr_audio_pkg.sv
// Shared widths and constants for the SSB audio output stage.
package sdr_audio_pkg;

  localparam int unsigned SAMPLE_W  = 16;
  localparam int unsigned I2S_SLOTS = 32;
  localparam int unsigned SLOT_W    = $clog2(I2S_SLOTS);

  localparam logic SB_USB = 1'b0;
  localparam logic SB_LSB = 1'b1;

  // LRCLK is high (right word select) on these slot entries, inclusive
  localparam logic [SLOT_W-1:0] LR_FIRST_SLOT = SLOT_W'(15);
  localparam logic [SLOT_W-1:0] LR_LAST_SLOT  = SLOT_W'(30);

  typedef logic [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/i2s_tx.sv
// Free-running Philips I2S transmitter: holding register, frame latch and
// serialiser sending the same mono word in both channels.
module i2s_tx
  import sdr_audio_pkg::*;
#(
  parameter int unsigned BCLK_HALF = 22
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    load_i,
  input  sample_t data_i,
  output logic    overrun_o,
  output logic    i2s_bclk_o,
  output logic    i2s_lrclk_o,
  output logic    i2s_sdata_o
);

  localparam int unsigned HCNT_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

  logic [HCNT_W-1:0] hcnt;
  logic [SLOT_W-1:0] slot;
  sample_t           hold;
  sample_t           frame;
  logic              pending;

  logic              wrap;
  logic              bfall;
  logic              enter0;
  logic [SLOT_W-1:0] slot_nxt;
  sample_t           bit_src;

  // Slot entry happens on the BCLK falling edge; slot 0 entry latches a new frame
  always_comb begin
    wrap     = (hcnt == HCNT_W'(BCLK_HALF - 1));
    bfall    = wrap & i2s_bclk_o;
    slot_nxt = slot + SLOT_W'(1);
    enter0   = bfall & (slot_nxt == '0);
    bit_src  = enter0 ? hold : frame;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hcnt        <= '0;
      slot        <= '0;
      hold        <= '0;
      frame       <= '0;
      pending     <= 1'b0;
      overrun_o   <= 1'b0;
      i2s_bclk_o  <= 1'b0;
      i2s_lrclk_o <= 1'b0;
      i2s_sdata_o <= 1'b0;
    end else begin
      hcnt <= wrap ? '0 : hcnt + HCNT_W'(1);
      if (wrap) i2s_bclk_o <= ~i2s_bclk_o;

      if (bfall) begin
        slot        <= slot_nxt;
        i2s_lrclk_o <= (slot_nxt >= LR_FIRST_SLOT) && (slot_nxt <= LR_LAST_SLOT);
        i2s_sdata_o <= bit_src[~slot_nxt[3:0]];
        if (enter0) frame <= hold;
      end

      // A load coinciding with the frame latch stays pending and is not an overrun
      if (load_i) begin
        hold      <= data_i;
        pending   <= 1'b1;
        overrun_o <= pending & ~enter0;
      end else begin
        overrun_o <= 1'b0;
        if (enter0) pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ssb_audio_out.sv
// SSB receive back end: I-path delay matching the Hilbert FIR, USB/LSB
// sum/difference, and mono I2S output.
module ssb_audio_out
  import sdr_audio_pkg::*;
#(
  parameter int unsigned DELAY     = 15,
  parameter int unsigned BCLK_HALF = 22
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                valid_i,
  input  logic [SAMPLE_W-1:0] i_i,
  input  logic [SAMPLE_W-1:0] q_hilbert_i,
  input  logic                sideband_i,
  output logic [SAMPLE_W-1:0] audio_o,
  output logic                audio_valid_o,
  output logic                overrun_o,
  output logic                i2s_bclk_o,
  output logic                i2s_lrclk_o,
  output logic                i2s_sdata_o
);

  sample_t             dline [DELAY];
  sample_t             i_d;
  logic [SAMPLE_W:0]   ext_i;
  logic [SAMPLE_W:0]   ext_q;
  logic [SAMPLE_W:0]   sum;
  sample_t             audio_nxt;

  // 17-bit sum of two sign-extended 16-bit values cannot overflow
  always_comb begin
    i_d       = dline[DELAY-1];
    ext_i     = {i_d[SAMPLE_W-1], i_d};
    ext_q     = {q_hilbert_i[SAMPLE_W-1], q_hilbert_i};
    sum       = (sideband_i == SB_LSB) ? (ext_i - ext_q) : (ext_i + ext_q);
    audio_nxt = sum[SAMPLE_W:1];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < int'(DELAY); k++) dline[k] <= '0;
      audio_o       <= '0;
      audio_valid_o <= 1'b0;
    end else begin
      audio_valid_o <= valid_i;
      if (valid_i) begin
        dline[0] <= i_i;
        for (int k = 1; k < int'(DELAY); k++) dline[k] <= dline[k-1];
        audio_o <= audio_nxt;
      end
    end
  end

  // Holding register loads alongside audio_o so overrun_o coincides with audio_valid_o
  i2s_tx #(
    .BCLK_HALF (BCLK_HALF)
  ) u_i2s_tx (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (valid_i),
    .data_i      (audio_nxt),
    .overrun_o   (overrun_o),
    .i2s_bclk_o  (i2s_bclk_o),
    .i2s_lrclk_o (i2s_lrclk_o),
    .i2s_sdata_o (i2s_sdata_o)
  );

endmodule

// File: tb/tb_ssb_audio_out.sv
// Directed scoreboard bench for ssb_audio_out with default parameters.
module tb_ssb_audio_out;

  localparam int DELAY = 15;
  localparam logic USB = 1'b0;
  localparam logic LSB = 1'b1;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [15:0] i_i;
  logic [15:0] q_hilbert_i;
  logic        sideband_i;
  logic [15:0] audio_o;
  logic        audio_valid_o;
  logic        overrun_o;
  logic        i2s_bclk_o;
  logic        i2s_lrclk_o;
  logic        i2s_sdata_o;

  int          cyc = 0;
  int          vectors = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] dl_model[$];
  logic [15:0] last_audio;

  ssb_audio_out dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .valid_i       (valid_i),
    .i_i           (i_i),
    .q_hilbert_i   (q_hilbert_i),
    .sideband_i    (sideband_i),
    .audio_o       (audio_o),
    .audio_valid_o (audio_valid_o),
    .overrun_o     (overrun_o),
    .i2s_bclk_o    (i2s_bclk_o),
    .i2s_lrclk_o   (i2s_lrclk_o),
    .i2s_sdata_o   (i2s_sdata_o)
  );

  always #8 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] model(input logic [15:0] idv, input logic [15:0] qv, input logic s);
    int a, b, r;
    a = int'($signed(idv));
    b = int'($signed(qv));
    r = s ? (a - b) : (a + b);
    return 16'(r >>> 1);
  endfunction

  // Drive one sample, push its expectation, pop and compare on audio_valid_o
  task automatic send(input logic [15:0] iv, input logic [15:0] qv, input logic s, output logic ov);
    logic [15:0] idv;
    @(negedge clk);
    valid_i = 1'b1; i_i = iv; q_hilbert_i = qv; sideband_i = s;
    idv = dl_model[$];
    dl_model.pop_back();
    dl_model.push_front(iv);
    exp_q.push_back(model(idv, qv, s));
    @(negedge clk);
    valid_i = 1'b0; sideband_i = ~s; q_hilbert_i = ~qv;
    check("audio_valid", 32'(audio_valid_o), 32'd1);
    last_audio = audio_o;
    ov = overrun_o;
    if (exp_q.size() > 0) check("audio", 32'(audio_o), 32'(exp_q.pop_front()));
    @(negedge clk);
    check("valid_pulse", 32'(audio_valid_o), 32'd0);
    check("audio_hold", 32'(audio_o), 32'(last_audio));
  endtask

  // Wait (bounded) until bclk (sel=0) or lrclk (sel=1) transitions to level 'to'
  task automatic wait_trans(input string tag, input bit sel, input logic to, output int at);
    logic prev, cur;
    int   n;
    logic timed_out;
    n = 0;
    timed_out = 1'b0;
    prev = sel ? i2s_lrclk_o : i2s_bclk_o;
    forever begin
      @(negedge clk);
      cur = sel ? i2s_lrclk_o : i2s_bclk_o;
      if (prev !== to && cur === to) break;
      prev = cur;
      n++;
      if (n > 4000) begin
        timed_out = 1'b1;
        break;
      end
    end
    if (timed_out) check({"timeout_", tag}, 32'(timed_out), 32'd0);
    at = cyc;
  endtask

  task automatic sync_slot0(output int at);
    int dummy;
    wait_trans("lr_fall", 1'b1, 1'b0, dummy);
    wait_trans("slot0", 1'b0, 1'b0, at);
  endtask

  // Sample sdata/lrclk at the next 32 BCLK rising edges
  task automatic read_frame(output logic [31:0] bits, output logic [31:0] lr, output int first_rise);
    int t;
    for (int s = 0; s < 32; s++) begin
      wait_trans("bclk_rise", 1'b0, 1'b1, t);
      if (s == 0) first_rise = t;
      bits[31-s] = i2s_sdata_o;
      lr[31-s]   = i2s_lrclk_o;
    end
  endtask

  initial begin
    logic        ov;
    int          t0, t1, ta, tb;
    logic [31:0] bits, lr;

    rst_i = 1'b1; valid_i = 1'b0; i_i = '0; q_hilbert_i = '0; sideband_i = USB;
    for (int k = 0; k < DELAY; k++) dl_model.push_back(16'd0);
    repeat (3) @(negedge clk);
    check("reset_outputs",
          32'({audio_o, audio_valid_o, overrun_o, i2s_bclk_o, i2s_lrclk_o, i2s_sdata_o}), 32'd0);
    rst_i = 1'b0;

    // Impulse through the delay line
    for (int k = 0; k <= DELAY + 1; k++) begin
      send((k == 0) ? 16'd1000 : 16'd0, 16'd0, USB, ov);
      check($sformatf("impulse_%0d", k), 32'(last_audio), (k == DELAY) ? 32'd500 : 32'd0);
    end

    // Sideband arithmetic
    repeat (DELAY) send(16'd1000, 16'd0, USB, ov);
    send(16'd1000, 16'd200, USB, ov);
    check("usb_600", 32'(last_audio), 32'd600);
    send(16'd1000, 16'd200, LSB, ov);
    check("lsb_400", 32'(last_audio), 32'd400);

    // Extremes
    send(16'h8000, 16'd0, USB, ov);
    send(16'h7fff, 16'd0, USB, ov);
    send(16'h0000, 16'd0, USB, ov);
    repeat (DELAY - 3) send(16'd0, 16'd0, USB, ov);
    send(16'd0, 16'h8000, USB, ov);
    check("min_plus_min", 32'(last_audio), 32'h8000);
    send(16'd0, 16'h8000, LSB, ov);
    check("max_minus_min", 32'(last_audio), 32'h7fff);
    send(16'd0, 16'h0001, LSB, ov);
    check("floor_neg1", 32'(last_audio), 32'hffff);

    // BCLK and frame timing
    sync_slot0(t0);
    wait_trans("bclk_rise", 1'b0, 1'b1, ta);
    wait_trans("bclk_rise", 1'b0, 1'b1, tb);
    check("bclk_period", 32'(tb - ta), 32'd44);
    sync_slot0(t1);
    check("frame_period", 32'(t1 - t0), 32'd1408);

    // Overrun: two loads inside one frame, second value is framed next
    repeat (DELAY) send(16'h8000, 16'd0, USB, ov);
    sync_slot0(t0);
    send(16'h8000, 16'd0, USB, ov);
    check("audio_a", 32'(last_audio), 32'hc000);
    check("overrun_first", 32'(ov), 32'd0);
    repeat (97) @(negedge clk);
    send(16'h8000, 16'h8002, USB, ov);
    check("audio_b", 32'(last_audio), 32'h8001);
    check("overrun_second", 32'(ov), 32'd1);
    sync_slot0(t0);
    read_frame(bits, lr, ta);
    check("frame_left", 32'(bits[31:16]), 32'h8001);
    check("frame_right", 32'(bits[15:0]), 32'h8001);
    check("lrclk_pattern", lr, 32'h0001fffe);

    // Reset in slot 20
    sync_slot0(t0);
    for (int k = 0; k < 20; k++) wait_trans("bclk_fall", 1'b0, 1'b0, t1);
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check("midframe_reset_outputs",
          32'({audio_o, audio_valid_o, overrun_o, i2s_bclk_o, i2s_lrclk_o, i2s_sdata_o}), 32'd0);
    t0 = cyc;
    read_frame(bits, lr, ta);
    check("first_bclk_rise", 32'(ta - t0), 32'd22);
    check("post_reset_frame", bits, 32'd0);
    check("post_reset_lrclk", lr, 32'h0001fffe);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
